// File: rtl/platform_scroller.sv
// platform_scroller: scrolls the game platforms, respawns those leaving the bottom, reports doodle landings
// Optional feature: define PLAT_DRIFT_EN to make odd-index platforms drift horizontally.
// Ports:
//   Clk, Reset            clock and synchronous active-high reset
//   Frame_tick            start-of-blanking pulse; starts one update pass when idle
//   Scroll, Scroll_amt    scroll request and pixel amount, latched on Frame_tick
//   Falling               doodle descending, latched on Frame_tick
//   Doodle_x, Doodle_y    doodle feet point, latched on Frame_tick
//   hCount, vCount        current VGA pixel
//   Hit                   one-cycle landing pulse at the end of a pass
//   Busy                  update pass in progress
//   Respawns              saturating count of respawned platforms
//   Pixel_on              previous cycle's pixel lies on a platform
module platform_scroller #(
   parameter int          NUM_PLAT = 4,
   parameter int          H_RES    = 640,
   parameter int          V_RES    = 480,
   parameter int          PLAT_W   = 40,
   parameter int          PLAT_H   = 8,
   parameter logic [15:0] SEED     = 16'hACE1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Frame_tick,
   input  logic       Scroll,
   input  logic [3:0] Scroll_amt,
   input  logic       Falling,
   input  logic [9:0] Doodle_x,
   input  logic [9:0] Doodle_y,
   input  logic [9:0] hCount,
   input  logic [9:0] vCount,
   output logic       Hit,
   output logic       Busy,
   output logic [7:0] Respawns,
   output logic       Pixel_on
);
   localparam int IW    = $clog2(NUM_PLAT);
   localparam int X_MAX = H_RES - PLAT_W;
   typedef enum logic [1:0] {IDLE, UPDATE, COLLIDE, REPORT} state_t;
   state_t        state, state_n;
   logic [IW-1:0] idx;
   logic [9:0]    px [NUM_PLAT];
   logic [9:0]    py [NUM_PLAT];
   logic [15:0]   lfsr, lfsr_n;
   logic          s_scroll, s_fall, hit_flag, last, wrap, on_x, on_y, pix_n;
   logic [3:0]    s_amt;
   logic [9:0]    s_dx, s_dy, rnd, new_x, drift_x;
   logic [10:0]   ny;

   assign last   = idx == IW'(NUM_PLAT - 1);
   assign ny     = {1'b0, py[idx]} + (s_scroll ? {7'b0, s_amt} : 11'd0);
   assign wrap   = ny >= 11'(V_RES);
   assign rnd    = lfsr[9:0];
   // fold out-of-range LFSR values back into the legal column range
   assign new_x  = rnd < 10'(X_MAX) ? rnd : rnd - 10'(X_MAX);
   assign lfsr_n = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   assign on_x   = s_dx >= px[idx] && {1'b0, s_dx} <= {1'b0, px[idx]} + 11'(PLAT_W - 1);
   assign on_y   = s_dy >= py[idx] && {1'b0, s_dy} <= {1'b0, py[idx]} + 11'(PLAT_H - 1);
   assign Busy   = state != IDLE;
   assign Hit    = state == REPORT && hit_flag;

`ifdef PLAT_DRIFT_EN
   logic [NUM_PLAT-1:0] dir;
   logic                at_edge;
   assign at_edge = dir[idx] ? px[idx] == 10'd0 : px[idx] == 10'(X_MAX);
   // at an edge the platform holds position for the reversal visit
   assign drift_x = (!idx[0] || at_edge) ? px[idx] : dir[idx] ? px[idx] - 10'd1 : px[idx] + 10'd1;
   always_ff @(posedge Clk)
      if (Reset)
         dir <= '0;
      else if (state == UPDATE && idx[0] && at_edge && !wrap)
         dir[idx] <= ~dir[idx];
`else
   assign drift_x = px[idx];
`endif

   always_ff @(posedge Clk)
      state <= Reset ? IDLE : state_n;

   always_comb begin
      state_n = state;
      state_n = state == IDLE    ? (Frame_tick ? UPDATE : IDLE) :
                state == UPDATE  ? (last ? COLLIDE : UPDATE) :
                state == COLLIDE ? (last ? REPORT : COLLIDE) : IDLE;
   end

   always_comb begin
      pix_n = 1'b0;
      for (int i = 0; i < NUM_PLAT; i++)
         pix_n = pix_n | (hCount >= px[i] && {1'b0, hCount} <= {1'b0, px[i]} + 11'(PLAT_W - 1) &&
                          vCount >= py[i] && {1'b0, vCount} <= {1'b0, py[i]} + 11'(PLAT_H - 1));
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_PLAT; i++) begin
            px[i] <= 10'(H_RES / 2 - PLAT_W / 2);
            py[i] <= 10'(i * (V_RES / NUM_PLAT) + V_RES / (2 * NUM_PLAT));
         end
         lfsr     <= SEED;
         idx      <= '0;
         hit_flag <= 1'b0;
         s_scroll <= 1'b0;
         s_fall   <= 1'b0;
         s_amt    <= '0;
         s_dx     <= '0;
         s_dy     <= '0;
         Respawns <= '0;
         Pixel_on <= 1'b0;
      end else begin
         Pixel_on <= pix_n;
         if (state == IDLE && Frame_tick) begin
            s_scroll <= Scroll;
            s_amt    <= Scroll_amt;
            s_fall   <= Falling;
            s_dx     <= Doodle_x;
            s_dy     <= Doodle_y;
            idx      <= '0;
            hit_flag <= 1'b0;
         end
         if (state == UPDATE) begin
            py[idx] <= wrap ? 10'(ny - 11'(V_RES)) : ny[9:0];
            px[idx] <= wrap ? new_x : drift_x;
            if (wrap) begin
               lfsr <= lfsr_n;
               if (Respawns != 8'hFF)
                  Respawns <= Respawns + 8'd1;
            end
         end
         if (state == COLLIDE && s_fall && on_x && on_y)
            hit_flag <= 1'b1;
         if (state == UPDATE || state == COLLIDE)
            idx <= last ? '0 : idx + IW'(1);
      end
   end
endmodule

// File: tb/tb_platform_scroller.sv
// tb_platform_scroller: directed self-checking bench for platform_scroller
module tb_platform_scroller;
   logic       Clk = 1'b0;
   logic       Reset, Frame_tick, Scroll, Falling, Hit, Busy, Pixel_on;
   logic [3:0] Scroll_amt;
   logic [9:0] Doodle_x, Doodle_y, hCount, vCount;
   logic [7:0] Respawns;
   int         tests = 0;
   int         fails = 0;

   always #5 Clk = ~Clk;

   platform_scroller dut (
      .Clk(Clk), .Reset(Reset), .Frame_tick(Frame_tick), .Scroll(Scroll), .Scroll_amt(Scroll_amt),
      .Falling(Falling), .Doodle_x(Doodle_x), .Doodle_y(Doodle_y), .hCount(hCount), .vCount(vCount),
      .Hit(Hit), .Busy(Busy), .Respawns(Respawns), .Pixel_on(Pixel_on)
   );

   task automatic frame(input logic sc, input logic [3:0] amt, input logic fall, input logic [9:0] dx, input logic [9:0] dy,
                        output int nhit, output int hit_cyc, output int nbusy, output int busy_end);
      Scroll = sc; Scroll_amt = amt; Falling = fall; Doodle_x = dx; Doodle_y = dy;
      nhit = 0; hit_cyc = -1; nbusy = 0; busy_end = -1;
      @(negedge Clk) Frame_tick = 1'b1;
      @(negedge Clk) Frame_tick = 1'b0;
      for (int c = 1; c < 15; c++) begin
         if (Hit) begin nhit++; hit_cyc = c; end
         if (Busy) begin nbusy++; busy_end = c; end
         @(negedge Clk);
      end
   endtask

   task automatic test_reset;
      int exp_py[4] = '{60, 180, 300, 420};
      Reset = 1'b1; Frame_tick = 1'b0; Scroll = 1'b0; Scroll_amt = '0; Falling = 1'b0;
      Doodle_x = '0; Doodle_y = '0; hCount = '0; vCount = '0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      tests++; if (Hit !== 1'b0) begin fails++; $display("FAIL reset_hit: got %0b expected 0", Hit); end
      tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", Busy); end
      tests++; if (Respawns !== 8'd0) begin fails++; $display("FAIL reset_respawns: got %0d expected 0", Respawns); end
      tests++; if (Pixel_on !== 1'b0) begin fails++; $display("FAIL reset_pixel: got %0b expected 0", Pixel_on); end
      for (int i = 0; i < 4; i++) begin
         tests++; if (dut.py[i] !== 10'(exp_py[i])) begin fails++; $display("FAIL reset_py%0d: got %0d expected %0d", i, dut.py[i], exp_py[i]); end
         tests++; if (dut.px[i] !== 10'd300) begin fails++; $display("FAIL reset_px%0d: got %0d expected 300", i, dut.px[i]); end
      end
   endtask

   task automatic test_pixel;
      int ones = 0;
      logic exp;
      vCount = 10'd60; hCount = 10'd295;
      @(negedge Clk);
      for (int h = 296; h <= 346; h++) begin
         hCount = 10'(h);
         #1;
         exp = (h - 1 >= 300) && (h - 1 <= 339);
         if (Pixel_on === 1'b1) ones++;
         tests++; if (Pixel_on !== exp) begin fails++; $display("FAIL pixel_h%0d: got %0b expected %0b", h - 1, Pixel_on, exp); end
         @(negedge Clk);
      end
      tests++; if (ones != 40) begin fails++; $display("FAIL pixel_width: got %0d expected 40", ones); end
      vCount = 10'd68; hCount = 10'd310;
      repeat (2) @(negedge Clk);
      tests++; if (Pixel_on !== 1'b0) begin fails++; $display("FAIL pixel_below: got %0b expected 0", Pixel_on); end
      vCount = 10'd67;
      repeat (2) @(negedge Clk);
      tests++; if (Pixel_on !== 1'b1) begin fails++; $display("FAIL pixel_bottom_row: got %0b expected 1", Pixel_on); end
   endtask

   task automatic test_landing;
      int nh, hc, nb, be;
      frame(1'b0, 4'd0, 1'b1, 10'd310, 10'd62, nh, hc, nb, be);
      tests++; if (nh != 1) begin fails++; $display("FAIL land_hits: got %0d expected 1", nh); end
      tests++; if (hc != 9) begin fails++; $display("FAIL land_hit_cycle: got %0d expected 9", hc); end
      tests++; if (nb != 9) begin fails++; $display("FAIL land_busy_cycles: got %0d expected 9", nb); end
      tests++; if (be != 9) begin fails++; $display("FAIL land_busy_end: got %0d expected 9", be); end
      frame(1'b0, 4'd0, 1'b0, 10'd310, 10'd62, nh, hc, nb, be);
      tests++; if (nh != 0) begin fails++; $display("FAIL land_not_falling: got %0d expected 0", nh); end
   endtask

   task automatic test_edges;
      int nh, hc, nb, be;
      frame(1'b0, 4'd0, 1'b1, 10'd299, 10'd62, nh, hc, nb, be);
      tests++; if (nh != 0) begin fails++; $display("FAIL edge_x299: got %0d expected 0", nh); end
      frame(1'b0, 4'd0, 1'b1, 10'd310, 10'd68, nh, hc, nb, be);
      tests++; if (nh != 0) begin fails++; $display("FAIL edge_y68: got %0d expected 0", nh); end
      frame(1'b0, 4'd0, 1'b1, 10'd339, 10'd67, nh, hc, nb, be);
      tests++; if (nh != 1) begin fails++; $display("FAIL edge_corner: got %0d expected 1", nh); end
      frame(1'b0, 4'd0, 1'b1, 10'd340, 10'd67, nh, hc, nb, be);
      tests++; if (nh != 0) begin fails++; $display("FAIL edge_x340: got %0d expected 0", nh); end
   endtask

   task automatic test_back_to_back;
      int nh = 0;
      int nb = 0;
      Scroll = 1'b0; Scroll_amt = '0; Falling = 1'b1; Doodle_x = 10'd310; Doodle_y = 10'd62;
      @(negedge Clk) Frame_tick = 1'b1;
      @(negedge Clk) Frame_tick = 1'b0;
      for (int c = 1; c < 25; c++) begin
         Frame_tick = (c == 4);
         if (Hit) nh++;
         if (Busy) nb++;
         @(negedge Clk);
      end
      Frame_tick = 1'b0;
      tests++; if (nh != 1) begin fails++; $display("FAIL busy_tick_hits: got %0d expected 1", nh); end
      tests++; if (nb != 9) begin fails++; $display("FAIL busy_tick_window: got %0d expected 9", nb); end
   endtask

   task automatic test_reset_mid;
      int nh = 0;
      Scroll = 1'b1; Scroll_amt = 4'd8; Falling = 1'b1; Doodle_x = 10'd310; Doodle_y = 10'd70;
      @(negedge Clk) Frame_tick = 1'b1;
      @(negedge Clk) Frame_tick = 1'b0;
      repeat (2) @(negedge Clk);
      tests++; if (dut.py[0] !== 10'd68) begin fails++; $display("FAIL mid_py0_scrolled: got %0d expected 68", dut.py[0]); end
      Reset = 1'b1;
      @(negedge Clk) Reset = 1'b0;
      tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %0b expected 0", Busy); end
      tests++; if (dut.py[0] !== 10'd60) begin fails++; $display("FAIL mid_py0: got %0d expected 60", dut.py[0]); end
      tests++; if (dut.py[1] !== 10'd180) begin fails++; $display("FAIL mid_py1: got %0d expected 180", dut.py[1]); end
      for (int c = 0; c < 12; c++) begin
         if (Hit) nh++;
         @(negedge Clk);
      end
      tests++; if (nh != 0) begin fails++; $display("FAIL mid_no_hit: got %0d expected 0", nh); end
   endtask

   task automatic test_scroll;
      int nh, hc, nb, be;
      int exp1[4] = '{123, 243, 363, 3};
      int exp2[4] = '{243, 363, 3, 123};
      repeat (3) frame(1'b1, 4'd15, 1'b0, 10'd0, 10'd0, nh, hc, nb, be);
      frame(1'b1, 4'd10, 1'b0, 10'd0, 10'd0, nh, hc, nb, be);
      tests++; if (dut.py[3] !== 10'd475) begin fails++; $display("FAIL scroll_py3_pre: got %0d expected 475", dut.py[3]); end
      tests++; if (Respawns !== 8'd0) begin fails++; $display("FAIL scroll_respawns_pre: got %0d expected 0", Respawns); end
      frame(1'b1, 4'd8, 1'b0, 10'd0, 10'd0, nh, hc, nb, be);
      for (int i = 0; i < 4; i++) begin
         tests++; if (dut.py[i] !== 10'(exp1[i])) begin fails++; $display("FAIL wrap1_py%0d: got %0d expected %0d", i, dut.py[i], exp1[i]); end
      end
      tests++; if (dut.px[3] !== 10'd225) begin fails++; $display("FAIL wrap1_px3: got %0d expected 225", dut.px[3]); end
      tests++; if (Respawns !== 8'd1) begin fails++; $display("FAIL wrap1_respawns: got %0d expected 1", Respawns); end
      repeat (8) frame(1'b1, 4'd15, 1'b0, 10'd0, 10'd0, nh, hc, nb, be);
      for (int i = 0; i < 4; i++) begin
         tests++; if (dut.py[i] !== 10'(exp2[i])) begin fails++; $display("FAIL wrap2_py%0d: got %0d expected %0d", i, dut.py[i], exp2[i]); end
      end
      tests++; if (dut.px[2] !== 10'd24) begin fails++; $display("FAIL wrap2_px2: got %0d expected 24", dut.px[2]); end
      tests++; if (Respawns !== 8'd2) begin fails++; $display("FAIL wrap2_respawns: got %0d expected 2", Respawns); end
   endtask

`ifdef PLAT_DRIFT_EN
   task automatic test_drift;
      int nh, hc, nb, be;
      Reset = 1'b1;
      @(negedge Clk) Reset = 1'b0;
      repeat (299) frame(1'b0, 4'd0, 1'b0, 10'd0, 10'd0, nh, hc, nb, be);
      tests++; if (dut.px[1] !== 10'd599) begin fails++; $display("FAIL drift_599: got %0d expected 599", dut.px[1]); end
      frame(1'b0, 4'd0, 1'b0, 10'd0, 10'd0, nh, hc, nb, be);
      tests++; if (dut.px[1] !== 10'd600) begin fails++; $display("FAIL drift_600: got %0d expected 600", dut.px[1]); end
      frame(1'b0, 4'd0, 1'b0, 10'd0, 10'd0, nh, hc, nb, be);
      tests++; if (dut.px[1] !== 10'd600) begin fails++; $display("FAIL drift_hold: got %0d expected 600", dut.px[1]); end
      tests++; if (dut.dir[1] !== 1'b1) begin fails++; $display("FAIL drift_dir: got %0b expected 1", dut.dir[1]); end
      frame(1'b0, 4'd0, 1'b0, 10'd0, 10'd0, nh, hc, nb, be);
      tests++; if (dut.px[1] !== 10'd599) begin fails++; $display("FAIL drift_back: got %0d expected 599", dut.px[1]); end
      tests++; if (dut.px[0] !== 10'd300) begin fails++; $display("FAIL drift_even_still: got %0d expected 300", dut.px[0]); end
   endtask
`endif

   initial begin
      test_reset;
      test_pixel;
      test_landing;
      test_edges;
      test_back_to_back;
      test_reset_mid;
      test_scroll;
`ifdef PLAT_DRIFT_EN
      test_drift;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/platform_scroller.md
# platform_scroller

Maintains the on-screen platforms for the doodle game: scrolls them down while the doodle climbs, respawns platforms that leave the bottom at a pseudo-random column, and reports landings. Sits directly upstream of the doodle jump state machine: its `Hit` pulse is the "hit block" condition that returns the jump FSM from DOWN to UP. Its `Pixel_on` output feeds the VGA colour mux.

## Interface
- `NUM_PLAT`, 4: number of platforms (2..8).
- `H_RES`, 640: screen width in pixels.
- `V_RES`, 480: screen height in pixels.
- `PLAT_W`, 40: platform width in pixels.
- `PLAT_H`, 8: platform height in pixels.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `Clk`  in  1  system clock; single clock domain.
- `Reset`  in  1  synchronous, active-high reset.
- `Frame_tick`  in  1  one-cycle pulse at the start of vertical blanking.
- `Scroll`  in  1  doodle is climbing above the scroll line; sampled at `Frame_tick`.
- `Scroll_amt`  in  4  pixels to scroll this frame; sampled at `Frame_tick`.
- `Falling`  in  1  jump FSM is in DOWN; sampled at `Frame_tick`.
- `Doodle_x`, `Doodle_y`  in  10 each  doodle feet point; sampled at `Frame_tick`.
- `hCount`, `vCount`  in  10 each  current VGA pixel.
- `Hit`  out  1  one-cycle landing pulse.
- `Busy`  out  1  update in progress.
- `Respawns`  out  8  count of respawned platforms, usable as a score.
- `Pixel_on`  out  1  current pixel lies on a platform.

## Operation
- Per platform i: `px[i]` (10 bit) and `py[i]` (10 bit), the top-left corner.
- Reset values:
  - `px[i]` = H_RES/2 − PLAT_W/2 (300).
  - `py[i]` = i·(V_RES/NUM_PLAT) + V_RES/(2·NUM_PLAT), giving 60, 180, 300, 420 at the defaults.
  - LFSR = SEED.
  - `Hit`, `Busy`, `Pixel_on` = 0; `Respawns` = 0; state IDLE.
- FSM states: IDLE, UPDATE, COLLIDE, REPORT.
- IDLE:
  - On `Frame_tick`, latch the doodle inputs, clear index and hit flag, and go to UPDATE.
- UPDATE (one platform per cycle, i = 0..NUM_PLAT−1):
  - If the latched Scroll is set, compute `ny` = `py[i]` + Scroll_amt using an 11-bit sum.
  - If `ny` ≥ V_RES, respawn:
    - `py[i]` = `ny` − V_RES (wrap to the top).
    - `px[i]` = LFSR[9:0] if that value is < H_RES−PLAT_W; otherwise LFSR[9:0] − (H_RES−PLAT_W).
    - LFSR advances one step (Galois, taps 16,14,13,11).
    - `Respawns` increments, saturating at 255.
  - Otherwise `py[i]` = `ny`.
  - After the last index, go to COLLIDE.
- COLLIDE (one platform per cycle):
  - Set the hit flag if latched Falling = 1, `px[i]` ≤ Doodle_x ≤ `px[i]`+PLAT_W−1, and `py[i]` ≤ Doodle_y ≤ `py[i]`+PLAT_H−1.
  - Compare against the updated positions.
  - After the last index, go to REPORT.
- REPORT:
  - `Hit` = hit flag for exactly this cycle.
  - Go to IDLE.
- While `Busy`, `Frame_tick` is ignored; it is not queued.
- Multiple platforms overlapping the doodle still produce a single `Hit`.
- LFSR advances only on a respawn, so sequences are deterministic per SEED.
- Reset asserted in any state restores all reset values on the next edge and aborts the update in progress, with no `Hit`.

## Timing
- Tick sampled at cycle 0.
- UPDATE occupies cycles 1..N; COLLIDE occupies cycles N+1..2N.
- `Hit` is high in cycle 2N+1 (cycle 9 at default N=4).
- `Busy` is high in cycles 1..2N+1.
- `Pixel_on` is registered and lags `hCount`/`vCount` by one cycle.
- `Pixel_on` uses the current `px`/`py`; updates land during blanking, so no tearing occurs.

## Configuration
- `PLAT_DRIFT_EN` defined:
  - Odd-index platforms move horizontally 1 px per UPDATE visit.
  - Each has a direction bit, reset 0 (rightward).
  - The platform reverses when `px` would exceed H_RES−PLAT_W or drop below 0; it stays at the edge on the reversal cycle.
  - A respawn keeps the platform's current direction.
- `PLAT_DRIFT_EN` undefined:
  - `px` changes only on respawn, and no direction registers exist.

## Test plan
- **Reset then idle:** after reset, `py` = 60/180/300/420 and `px` = 300. Sweep hCount 300..339 at vCount 60 → `Pixel_on` = 1 one cycle later; hCount 340 → 0.
- **Scroll with wrap:** set `py[3]` = 475, Scroll = 1, Scroll_amt = 8, pulse tick → `py[3]` = 3, `px[3]` derived from SEED, `Respawns` = 1; the other platforms each increase by 8.
- **Landing:** Falling = 1, Doodle = (310, 62), Scroll = 0 → `Hit` high for one cycle at cycle 9 and `Busy` low at cycle 10. With Falling = 0 and the same position → no `Hit`.
- **Edge bounds:** Doodle_x = 299 or Doodle_y = 68 → no `Hit`. Doodle_x = 339 and Doodle_y = 67 → `Hit`.
- **Tick while busy, and reset mid-update:**
  - A second tick at cycle 4 is ignored, giving exactly one `Hit`/`Busy` window.
  - Reset asserted at cycle 3 → all reset values restored next cycle and no `Hit`.
- **Drift (`PLAT_DRIFT_EN` defined):** set `px[1]` = 599 moving right, then pulse 2 ticks → 600, then 600 with the direction reversed. A third tick → 599.
